// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: all request/response signals between the two
// requesting ports, the arbiter and the memory, kept in one bundle.
//   Port 0 (instruction fetch, read-only): if_req_i, if_addr_i / if_gnt_o,
//     if_rvalid_o, if_rdata_o
//   Port 1 (data, read/write): d_req_i, d_we_i, d_addr_i, d_wdata_i,
//     d_wstrb_i / d_gnt_o, d_rvalid_o, d_rdata_o
//   Memory side: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o /
//     mem_gnt_i, mem_rvalid_i, mem_rdata_i
//   Status: err_o (sticky unexpected-read-data flag)
// Modports: slave = the arbiter's view, master = the view of whatever drives
// the ports and models the memory.
//
// Handshake: a port raises req with its fields and holds all of them stable
// until the cycle its gnt is 1; that cycle is the transfer. The memory sees
// the same rule on mem_req_o/mem_gnt_i. Read data returns as a one-cycle
// rvalid pulse with rdata valid in that same cycle; there is no back-pressure
// on read data.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128
);
  localparam int STRB_W = DATA_W / 8;

  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic [DATA_W-1:0] if_rdata_o;

  logic              d_req_i;
  logic              d_we_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [DATA_W-1:0] d_wdata_i;
  logic [STRB_W-1:0] d_wstrb_i;
  logic              d_gnt_o;
  logic              d_rvalid_o;
  logic [DATA_W-1:0] d_rdata_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [STRB_W-1:0] mem_wstrb_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [DATA_W-1:0] mem_rdata_i;

  logic              err_o;

  modport slave (
    input  if_req_i, if_addr_i,
    input  d_req_i, d_we_i, d_addr_i, d_wdata_i, d_wstrb_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    output d_gnt_o, d_rvalid_o, d_rdata_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
    output err_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output d_req_i, d_we_i, d_addr_i, d_wdata_i, d_wstrb_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    input  d_gnt_o, d_rvalid_o, d_rdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
    input  err_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between an instruction-fetch
// read port (port 0) and a read/write data port (port 1). One memory
// transaction is outstanding at a time; the request to memory is registered.
//
// Ports:
//   clk_i        single clock
//   rst_ni       asynchronous active-low reset
//   bus          mem_port_arbiter_if.slave (port 0, port 1, memory, err_o)
//   dbg_state_o  current FSM state (0 IDLE, 1 REQ, 2 WAIT_RD)
//
// Configuration macro ARB_ROUND_ROBIN_EN: when defined, contention goes to
// the port that was not granted last. When undefined, the data port always
// wins contention and no pointer register exists.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  mem_port_arbiter_if.slave    bus,
  output logic [1:0]           dbg_state_o
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_WAIT_RD = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              owner_q;     // 0: instruction port, 1: data port
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [STRB_W-1:0] mem_wstrb_q;
  logic              err_q;

  logic any_req;
  logic win_d;      // arbitration result: 1 selects the data port
  logic gnt_hit;    // memory accepts the outstanding request this cycle
  logic rd_done;    // read data for the owner arrives this cycle

  // Arbitration
`ifdef ARB_ROUND_ROBIN_EN
  logic last_q;     // port granted most recently
  assign win_d = bus.d_req_i && (!bus.if_req_i || !last_q);
`else
  assign win_d = bus.d_req_i;
`endif

  always_comb begin
    any_req = bus.if_req_i || bus.d_req_i;
    gnt_hit = (state_q == S_REQ) && bus.mem_gnt_i;
    // Read data is accepted in WAIT_RD, or in the grant cycle of a read when
    // the memory answers at once. Anything else is unexpected.
    rd_done = bus.mem_rvalid_i &&
              ((state_q == S_WAIT_RD) || (gnt_hit && !mem_we_q));
  end

  // State register and registered memory request
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      err_q       <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      mem_req_q <= (state_d == S_REQ);
      // Fields are captured only on arbitration; they stay frozen through
      // REQ so the memory sees a stable request.
      if ((state_q == S_IDLE) && any_req) begin
        owner_q     <= win_d;
        mem_we_q    <= win_d ? bus.d_we_i : 1'b0;
        mem_addr_q  <= win_d ? bus.d_addr_i : bus.if_addr_i;
        mem_wdata_q <= win_d ? bus.d_wdata_i : '0;
        mem_wstrb_q <= win_d ? bus.d_wstrb_i : '0;
      end
      if (bus.mem_rvalid_i && !rd_done) begin
        err_q <= 1'b1;
      end
`ifdef ARB_ROUND_ROBIN_EN
      if (gnt_hit) begin
        last_q <= owner_q;
      end
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) state_d = S_REQ;
      end
      S_REQ: begin
        if (gnt_hit) begin
          if (mem_we_q || rd_done) state_d = S_IDLE;
          else                     state_d = S_WAIT_RD;
        end
      end
      S_WAIT_RD: begin
        if (rd_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  logic              if_gnt, d_gnt, if_rvalid, d_rvalid;
  logic [DATA_W-1:0] if_rdata, d_rdata;

  always_comb begin
    if_gnt    = gnt_hit && !owner_q;
    d_gnt     = gnt_hit && owner_q;
    if_rvalid = rd_done && !owner_q;
    d_rvalid  = rd_done && owner_q;
    if_rdata  = if_rvalid ? bus.mem_rdata_i : '0;
    d_rdata   = d_rvalid ? bus.mem_rdata_i : '0;
  end

  assign bus.if_gnt_o    = if_gnt;
  assign bus.d_gnt_o     = d_gnt;
  assign bus.if_rvalid_o = if_rvalid;
  assign bus.d_rvalid_o  = d_rvalid;
  assign bus.if_rdata_o  = if_rdata;
  assign bus.d_rdata_o   = d_rdata;
  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.mem_wstrb_o = mem_wstrb_q;
  assign bus.err_o       = err_q;
  assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 128;
  localparam int STRB_W = DATA_W / 8;
  localparam int W      = DATA_W + 1;   // {port, rdata}

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT_RD = 2'd2;

  // Clock / reset
  logic       clk = 1'b0;
  logic       rst_ni;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_q[$];

  task automatic check_val(input string name, input logic [127:0] act,
                           input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Scoreboard: every port rvalid must match the oldest expected entry
  logic [W-1:0] mon_exp;
  always begin
    @(negedge clk);
    #2;
    if (bus.if_rvalid_o || bus.d_rvalid_o) begin
      check_bit("single_rvalid", bus.if_rvalid_o && bus.d_rvalid_o, 1'b0);
      if (exp_q.size() == 0) begin
        check_bit("rvalid_without_expectation", 1'b1,
                  !(bus.if_rvalid_o || bus.d_rvalid_o));
      end else begin
        mon_exp = exp_q.pop_front();
        check_bit("rvalid_port", bus.d_rvalid_o, mon_exp[DATA_W]);
        if (bus.d_rvalid_o) begin
          check_val("d_rdata", bus.d_rdata_o, mon_exp[DATA_W-1:0]);
          check_val("if_rdata_non_owner", bus.if_rdata_o, '0);
        end else begin
          check_val("if_rdata", bus.if_rdata_o, mon_exp[DATA_W-1:0]);
          check_val("d_rdata_non_owner", bus.d_rdata_o, '0);
        end
      end
    end
  end

  // Vector table
  typedef struct {
    logic              port;      // 0 instruction, 1 data
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    int                gnt_dly;   // cycles of mem_req before mem_gnt
    int                rv_dly;    // cycles after grant until rvalid (0 = same)
    logic [DATA_W-1:0] rdata;
    logic              exp_we;
    logic [DATA_W-1:0] exp_wdata;
    logic [STRB_W-1:0] exp_wstrb;
  } vec_t;

  localparam int N_VEC = 6;
  vec_t vecs[N_VEC];

  task automatic drive_idle();
    bus.if_req_i     = 1'b0;
    bus.if_addr_i    = '0;
    bus.d_req_i      = 1'b0;
    bus.d_we_i       = 1'b0;
    bus.d_addr_i     = '0;
    bus.d_wdata_i    = '0;
    bus.d_wstrb_i    = '0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
  endtask

  // Driver: one complete transaction on a single port
  task automatic run_txn(input vec_t v);
    logic [W-1:0] e;
    e = {v.port, v.rdata};
    @(negedge clk);
    check_bit("idle_before_req", bus.mem_req_o, 1'b0);
    if (v.port) begin
      bus.d_req_i   = 1'b1;
      bus.d_we_i    = v.we;
      bus.d_addr_i  = v.addr;
      bus.d_wdata_i = v.wdata;
      bus.d_wstrb_i = v.wstrb;
    end else begin
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = v.addr;
      // data-port fields idle but non-zero must not leak onto a port-0 txn
      bus.d_wdata_i = rand_line();
      bus.d_wstrb_i = '1;
    end
    @(negedge clk);
    check_bit("mem_req_latency", bus.mem_req_o, 1'b1);
    check_bit("mem_we", bus.mem_we_o, v.exp_we);
    check_val("mem_addr", 128'(bus.mem_addr_o), 128'(v.addr));
    check_val("mem_wdata", bus.mem_wdata_o, v.exp_wdata);
    check_val("mem_wstrb", 128'(bus.mem_wstrb_o), 128'(v.exp_wstrb));
    for (int k = 0; k <= v.gnt_dly; k++) begin
      if (k == v.gnt_dly) begin
        bus.mem_gnt_i = 1'b1;
        if (!v.we && v.rv_dly == 0) begin
          exp_q.push_back(e);
          bus.mem_rvalid_i = 1'b1;
          bus.mem_rdata_i  = v.rdata;
        end
        #1;
        check_bit("owner_gnt", v.port ? bus.d_gnt_o : bus.if_gnt_o, 1'b1);
        check_bit("other_gnt", v.port ? bus.if_gnt_o : bus.d_gnt_o, 1'b0);
      end else begin
        #1;
        check_bit("gnt_before_mem_gnt", bus.if_gnt_o || bus.d_gnt_o, 1'b0);
        @(negedge clk);
        check_bit("mem_req_held", bus.mem_req_o, 1'b1);
        check_val("mem_addr_frozen", 128'(bus.mem_addr_o), 128'(v.addr));
      end
    end
    @(negedge clk);
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.if_req_i     = 1'b0;
    bus.d_req_i      = 1'b0;
    check_bit("mem_req_drop", bus.mem_req_o, 1'b0);
    if (v.we || v.rv_dly == 0) begin
      check_val("state_after_grant", 128'(dbg_state), 128'(ST_IDLE));
    end else begin
      check_val("state_wait_rd", 128'(dbg_state), 128'(ST_WAIT_RD));
      for (int k = 1; k < v.rv_dly; k++) @(negedge clk);
      exp_q.push_back(e);
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = v.rdata;
      @(negedge clk);
      bus.mem_rvalid_i = 1'b0;
      bus.mem_rdata_i  = rand_line();
      check_val("state_after_rvalid", 128'(dbg_state), 128'(ST_IDLE));
    end
  endtask

  logic              exp_d;
  logic [DATA_W-1:0] rd;
  logic [DATA_W-1:0] wd;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Table: {inputs, expected memory-side fields}
    wd = rand_line();
    vecs[0] = '{port: 1'b0, we: 1'b0, addr: 32'h0000_0100, wdata: '0, wstrb: '0,
                gnt_dly: 2, rv_dly: 3, rdata: {16{8'hA5}},
                exp_we: 1'b0, exp_wdata: '0, exp_wstrb: '0};
    vecs[1] = '{port: 1'b1, we: 1'b1, addr: 32'h0000_0040, wdata: wd, wstrb: 16'h000F,
                gnt_dly: 0, rv_dly: 0, rdata: '0,
                exp_we: 1'b1, exp_wdata: wd, exp_wstrb: 16'h000F};
    vecs[2] = '{port: 1'b0, we: 1'b0, addr: 32'h0000_2000, wdata: '0, wstrb: '0,
                gnt_dly: 1, rv_dly: 1, rdata: rand_line(),
                exp_we: 1'b0, exp_wdata: '0, exp_wstrb: '0};
    vecs[3] = '{port: 1'b1, we: 1'b0, addr: 32'hFFFF_FFF0, wdata: '0, wstrb: '0,
                gnt_dly: 0, rv_dly: 0, rdata: rand_line(),
                exp_we: 1'b0, exp_wdata: '0, exp_wstrb: '0};
    wd = rand_line();
    vecs[4] = '{port: 1'b1, we: 1'b1, addr: 32'h1234_5670, wdata: wd, wstrb: 16'hFFFF,
                gnt_dly: 3, rv_dly: 0, rdata: '0,
                exp_we: 1'b1, exp_wdata: wd, exp_wstrb: 16'hFFFF};
    vecs[5] = '{port: 1'b1, we: 1'b0, addr: 32'h0000_0800, wdata: '0, wstrb: '0,
                gnt_dly: $urandom_range(0, 3), rv_dly: $urandom_range(1, 4),
                rdata: rand_line(),
                exp_we: 1'b0, exp_wdata: '0, exp_wstrb: '0};

    rst_ni = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    // Reset state
    check_bit("rst_mem_req", bus.mem_req_o, 1'b0);
    check_bit("rst_mem_we", bus.mem_we_o, 1'b0);
    check_val("rst_mem_addr", 128'(bus.mem_addr_o), '0);
    check_val("rst_mem_wdata", bus.mem_wdata_o, '0);
    check_val("rst_mem_wstrb", 128'(bus.mem_wstrb_o), '0);
    check_bit("rst_err", bus.err_o, 1'b0);
    check_val("rst_state", 128'(dbg_state), 128'(ST_IDLE));
    rst_ni = 1'b1;

    // Table-driven single-port transactions
    for (int i = 0; i < N_VEC; i++) run_txn(vecs[i]);
    check_bit("err_clean_after_table", bus.err_o, 1'b0);

    // Contention: both ports hold reads; memory grants and answers at once,
    // so every transaction is REQ followed by one IDLE gap.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.mem_gnt_i    = 1'b0;
      bus.mem_rvalid_i = 1'b0;
      if (i == 0) begin
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h0000_1000;
        bus.d_req_i   = 1'b1;
        bus.d_we_i    = 1'b0;
        bus.d_addr_i  = 32'h0000_2000;
      end
      check_bit("contend_idle_gap", bus.mem_req_o, 1'b0);
      @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
      exp_d = (i % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      check_bit("contend_mem_req", bus.mem_req_o, 1'b1);
      check_val("contend_addr", 128'(bus.mem_addr_o),
                exp_d ? 128'h2000 : 128'h1000);
      rd = rand_line();
      exp_q.push_back({exp_d, rd});
      bus.mem_gnt_i    = 1'b1;
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = rd;
      #1;
      check_bit("contend_d_gnt", bus.d_gnt_o, exp_d);
      check_bit("contend_if_gnt", bus.if_gnt_o, !exp_d);
    end
    @(negedge clk);
    drive_idle();
    check_bit("err_clean_after_contention", bus.err_o, 1'b0);

    // Stray rvalid while IDLE
    @(negedge clk);
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = rand_line();
    #1;
    check_bit("stray_no_if_rvalid", bus.if_rvalid_o, 1'b0);
    check_bit("stray_no_d_rvalid", bus.d_rvalid_o, 1'b0);
    @(negedge clk);
    bus.mem_rvalid_i = 1'b0;
    check_bit("stray_err_set", bus.err_o, 1'b1);
    repeat (3) @(negedge clk);
    check_bit("stray_err_sticky", bus.err_o, 1'b1);

    // Reset during WAIT_RD, late rvalid after release
    @(negedge clk);
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h0000_0300;
    @(negedge clk);
    bus.mem_gnt_i = 1'b1;
    #1;
    check_bit("abort_if_gnt", bus.if_gnt_o, 1'b1);
    @(negedge clk);
    bus.mem_gnt_i = 1'b0;
    bus.if_req_i  = 1'b0;
    check_val("abort_in_wait_rd", 128'(dbg_state), 128'(ST_WAIT_RD));
    @(negedge clk);
    rst_ni = 1'b0;
    #1;
    check_bit("abort_mem_req", bus.mem_req_o, 1'b0);
    check_val("abort_mem_addr", 128'(bus.mem_addr_o), '0);
    check_val("abort_state", 128'(dbg_state), 128'(ST_IDLE));
    check_bit("abort_err_cleared", bus.err_o, 1'b0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = rand_line();
    #1;
    check_bit("late_no_if_rvalid", bus.if_rvalid_o, 1'b0);
    check_bit("late_no_d_rvalid", bus.d_rvalid_o, 1'b0);
    @(negedge clk);
    bus.mem_rvalid_i = 1'b0;
    check_bit("late_err_set", bus.err_o, 1'b1);

    repeat (2) @(negedge clk);
    check_val("scoreboard_drained", 128'(exp_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, memory byte-address width.
REQ-002 Parameter DATA_W, default 128, line width in bits; strobe width is DATA_W/8.
REQ-003 clk_i  in  1  single clock for all logic.
REQ-004 rst_ni  in  1  asynchronous active-low reset.
REQ-005 if_req_i / if_addr_i  in  1 / ADDR_W  instruction-fetch read request (port 0, read-only) and its address.
REQ-006 if_gnt_o / if_rvalid_o / if_rdata_o  out  1 / 1 / DATA_W  port-0 grant, read-data valid, read data.
REQ-007 d_req_i, d_we_i, d_addr_i, d_wdata_i, d_wstrb_i  in  1, 1, ADDR_W, DATA_W, DATA_W/8  data-port (port 1) request.
REQ-008 d_gnt_o / d_rvalid_o / d_rdata_o  out  1 / 1 / DATA_W  port-1 grant, read-data valid, read data.
REQ-009 mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o  out  1, 1, ADDR_W, DATA_W, DATA_W/8  registered request to the memory.
REQ-010 mem_gnt_i / mem_rvalid_i / mem_rdata_i  in  1 / 1 / DATA_W  memory grant, read-valid, read data.
REQ-011 err_o  out  1  sticky flag: mem_rvalid_i seen while no read outstanding.

Function
REQ-012 FSM states IDLE, REQ, WAIT_RD; exactly one memory transaction outstanding at any time.
REQ-013 Port request SHALL be held stable (req, we, addr, wdata, wstrb) until its gnt; the arbiter does not sample changes before gnt.
REQ-014 IDLE: if any port requests, select winner, register its fields onto mem_* outputs, record owner, go to REQ; mem_req_o rises the cycle after the request is seen (1-cycle latency).
REQ-015 Port 0 transactions SHALL drive mem_we_o=0, mem_wdata_o=0, mem_wstrb_o=0.
REQ-016 REQ: mem_req_o=1 and all mem_* fields frozen until mem_gnt_i; owner SHALL NOT change while in REQ.
REQ-017 In the cycle mem_gnt_i=1 in REQ, the owner's gnt output SHALL be 1 (combinational from mem_gnt_i); the other port's gnt is 0; mem_req_o drops the next cycle.
REQ-018 On grant: write -> IDLE; read -> WAIT_RD.
REQ-019 WAIT_RD: on mem_rvalid_i=1, owner's rvalid output = 1 for that cycle with rdata = mem_rdata_i, then -> IDLE; the non-owner's rvalid is 0 and rdata is all zero.
REQ-020 mem_rvalid_i coincident with mem_gnt_i in REQ for a read SHALL be delivered in that cycle and the FSM SHALL go directly to IDLE.
REQ-021 mem_rvalid_i outside a pending read: ignored for both ports, err_o set to 1 until reset.
REQ-022 New arbitration happens only in IDLE; back-to-back transactions have one idle cycle on mem_req_o between them.
REQ-023 Simultaneous if_req_i and d_req_i in IDLE resolved per REQ-027/REQ-028.

Reset
REQ-024 During reset: state IDLE, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, mem_wstrb_o=0, all gnt/rvalid outputs 0, rdata outputs 0, err_o=0, owner=port 0, round-robin pointer=port 0.
REQ-025 Reset asserted mid-transaction aborts it immediately; no late rvalid is forwarded after deassertion (it sets err_o).
REQ-026 Outputs reach reset values asynchronously; first arbitration on the first rising edge after deassertion.

Configuration
REQ-027 Macro ARB_ROUND_ROBIN_EN defined: on contention the port not served last wins; the pointer updates on each grant.
REQ-028 Macro not defined: fixed priority, data port (port 1) always wins contention; no pointer register.

Verification
REQ-029 Single if read addr 0x100, mem_gnt 2 cycles after mem_req, rvalid 3 cycles later with 0xA5..A5 -> mem_req one cycle after if_req, if_gnt with mem_gnt, if_rvalid 1 cycle with 0xA5..A5, d_rvalid 0.
REQ-030 d write addr 0x40, wstrb 0x000F, mem_gnt immediate -> mem_we=1, d_gnt 1 cycle, FSM IDLE next cycle, no rvalid.
REQ-031 Both ports request from reset, repeatedly, gnt same cycle -> with ARB_ROUND_ROBIN_EN grants d,if,d,if; without it d always wins while d_req held.
REQ-032 mem_rvalid pulse while IDLE -> no port rvalid, err_o=1 and stays 1.
REQ-033 rst_ni low while in WAIT_RD, rvalid arrives after release -> all outputs reset, no forwarded rvalid, err_o=1.
REQ-034 Read with mem_gnt and mem_rvalid same cycle -> owner gnt and rvalid same cycle, next mem_req after one idle cycle.
